score_bcd_disp: RTL and testbench
=================================

Name: score_bcd_disp

Overview:
Downstream stage of the game core. It takes the signed binary game score and clamps it to 0..MAX_SCORE. A sequential double-dabble then converts it to four BCD digits, which are driven onto the four score 7-segment displays (thousands, hundreds, tens, units). This replaces the per-cycle divide/modulo path with a fixed-latency, single-shift-register converter and adds a one-deep pending buffer for score updates.

Parameters:
SCORE_W, 16, width of the signed score input (two's complement).
MAX_SCORE, 9999, upper clamp value; must be <= 9999 and < 2^(SCORE_W-1).
TIPO_DISPLAY, 0, 0 = common anode (segments active-low), 1 = common cathode (segments active-high).

Ports:
clk50  in  1  system clock, 50 MHz, rising edge.
reset  in  1  asynchronous, active-low reset.
score  in  SCORE_W  signed score from the game core.
score_vld  in  1  one-cycle request: score is sampled on this cycle.
busy  out  1  conversion in progress.
done  out  1  one-cycle pulse: new digits are visible on the Dsc* outputs.
sat_hi  out  1  last displayed value was clamped to MAX_SCORE.
sat_lo  out  1  last displayed value was clamped from a negative score to 0.
DscM  out  7  thousands digit segments, bit6=g .. bit0=a.
DscC  out  7  hundreds digit segments.
DscD  out  7  tens digit segments.
DscU  out  7  units digit segments.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE; busy, done, sat_hi, sat_lo = 0; pending flag = 0.
  - All four Dsc* outputs show "0": 7'b1000000 for TIPO_DISPLAY=0, the bitwise inverse for TIPO_DISPLAY=1.
- Segment code table (TIPO_DISPLAY=0), digits 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - TIPO_DISPLAY=1 inverts every bit.
  - "Blank" means all segments off: 7'h7F for anode, 7'h00 for cathode.
- FSM states: IDLE, CLAMP, SHIFT, UPDATE.
  - IDLE: on score_vld=1, capture score into work_reg and go to CLAMP. busy rises on the next edge.
  - CLAMP (1 cycle): signed compare on the full SCORE_W bits.
    - score < 0: value = 0, set the new sat_lo.
    - score > MAX_SCORE: value = MAX_SCORE, set the new sat_hi.
    - Otherwise value = score.
    - Load a 14-bit binary field plus a 16-bit BCD field (cleared). Iteration counter = 0.
  - SHIFT (exactly 14 cycles): each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1. The counter increments; on counter = 13, go to UPDATE.
  - UPDATE (1 cycle):
    - Register the four decoded nibbles into DscM/C/D/U.
    - Drive sat_hi/sat_lo from the CLAMP result.
    - done = 1 for this cycle only.
    - If the pending flag is set: clear it, load pending_score into work_reg, go to CLAMP (busy stays 1).
    - Otherwise go to IDLE (busy = 0).
- Latency: score_vld sampled at edge N, so new Dsc* values and done=1 appear after edge N+16.
- Throughput: one conversion per 16 cycles.
- score_vld while busy=1: store score in pending_score and set the pending flag.
  - A later score_vld before it is consumed overwrites the stored value (latest wins).
  - No request is ever dropped except by such an overwrite.
- score_vld in the same cycle as UPDATE with the pending flag clear: treat it as the next request, go to CLAMP.
- Dsc* outputs change only in UPDATE; they hold their value during conversion, so there are no intermediate digits.
- Reset mid-conversion: abort immediately and return outputs to the reset values. No done pulse is produced and the pending value is discarded.

Optional Feature:
Macro SCORE_LZ_BLANK_EN.
- Defined: leading zero digits in M, C, D are driven blank. The units digit always shows, so score 50 displays as "  50" and 0 as "   0". The reset value is "   0".
- Undefined: all four digits always show numerals, including leading zeros ("0050").

Test Plan:
1. Assert reset, release -> Dsc* = 1000000 ×4, busy=0, done=0, sat_hi=sat_lo=0.
2. score=1234, score_vld 1 cycle -> done exactly 16 cycles later, plus:
   - DscM=1111001, DscC=0100100, DscD=0110000, DscU=0011001.
   - busy high for 16 cycles.
3. score=-5 -> "0000", sat_lo=1, sat_hi=0. Then score=12000 -> all digits 0010000 ("9999"), sat_hi=1, sat_lo=0.
4. score=50 request, then score=70 at cycle 4 and score=95 at cycle 8 of the conversion -> first done shows 0050, then the next conversion starts with no IDLE gap. The second done shows 0095 (70 overwritten); exactly 2 done pulses total.
5. score=4321, assert reset during SHIFT cycle 7 -> outputs return to "0000" immediately, no done pulse, busy=0. A fresh request converts normally.
6. With SCORE_LZ_BLANK_EN defined, score=7 -> DscM=DscC=DscD=1111111, DscU=1111000. Repeat with TIPO_DISPLAY=1 -> all patterns inverted.

Source files
------------

// File: rtl/score_bcd_disp.sv
// Clamps a signed game score to 0..MAX_SCORE and converts it to four 7-segment digits using a sequential double-dabble.
// Define SCORE_LZ_BLANK_EN to blank leading zeros in the thousands, hundreds and tens digits.
module score_bcd_disp #(
   parameter int SCORE_W      = 16,
   parameter int MAX_SCORE    = 9999,
   parameter int TIPO_DISPLAY = 0
) (
   input  logic                      clk50,
   input  logic                      reset,
   input  logic signed [SCORE_W-1:0] score,
   input  logic                      score_vld,
   output logic                      busy,
   output logic                      done,
   output logic                      sat_hi,
   output logic                      sat_lo,
   output logic [6:0]                DscM,
   output logic [6:0]                DscC,
   output logic [6:0]                DscD,
   output logic [6:0]                DscU
);

   typedef enum logic [1:0] {IDLE, CLAMP, SHIFT, UPDATE} state_t;

   localparam logic signed [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_SCORE);
   localparam logic [13:0] MAX_BIN   = 14'(MAX_SCORE);
   localparam logic [6:0]  SEG_INV   = (TIPO_DISPLAY != 0) ? 7'h7F : 7'h00;
   localparam logic [6:0]  SEG_BLANK = 7'h7F ^ SEG_INV;
   localparam logic [6:0]  SEG_ZERO  = 7'b1000000 ^ SEG_INV;
`ifdef SCORE_LZ_BLANK_EN
   localparam logic [6:0]  SEG_RST_LEAD = SEG_BLANK;
`else
   localparam logic [6:0]  SEG_RST_LEAD = SEG_ZERO;
`endif

   function automatic logic [6:0] f_seg(input logic [3:0] d);
      logic [6:0] v;
      case (d)
         4'd0:    v = 7'b1000000;
         4'd1:    v = 7'b1111001;
         4'd2:    v = 7'b0100100;
         4'd3:    v = 7'b0110000;
         4'd4:    v = 7'b0011001;
         4'd5:    v = 7'b0010010;
         4'd6:    v = 7'b0000010;
         4'd7:    v = 7'b1111000;
         4'd8:    v = 7'b0000000;
         4'd9:    v = 7'b0010000;
         default: v = 7'h7F;
      endcase
      return v ^ SEG_INV;
   endfunction

   state_t                    r_state;
   state_t                    w_state_next;
   logic signed [SCORE_W-1:0] r_work;
   logic signed [SCORE_W-1:0] r_pend_score;
   logic                      r_pend;
   logic [13:0]               r_bin;
   logic [15:0]               r_bcd;
   logic [3:0]                r_cnt;
   logic                      r_clamp_hi;
   logic                      r_clamp_lo;
   logic                      r_busy;
   logic                      r_done;
   logic                      r_sat_hi;
   logic                      r_sat_lo;
   logic [6:0]                r_dsc_m;
   logic [6:0]                r_dsc_c;
   logic [6:0]                r_dsc_d;
   logic [6:0]                r_dsc_u;

   logic                      w_is_neg;
   logic                      w_is_hi;
   logic [13:0]               w_clamped;
   logic [15:0]               w_bcd_adj;
   logic [29:0]               w_shift;
   logic [6:0]                w_seg [4];
   logic                      w_blank_m;
   logic                      w_blank_c;
   logic                      w_blank_d;
   logic [6:0]                w_dsc_m;
   logic [6:0]                w_dsc_c;
   logic [6:0]                w_dsc_d;

   assign w_is_neg  = (r_work < 0);
   assign w_is_hi   = (r_work > MAX_S);
   assign w_clamped = w_is_neg ? 14'd0 : (w_is_hi ? MAX_BIN : 14'(r_work));

   // Double-dabble correction on every BCD nibble, then shift bcd:bin left by one.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_nib
         assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                       (r_bcd[gi*4 +: 4] + 4'd3) : r_bcd[gi*4 +: 4];
         assign w_seg[gi] = f_seg(r_bcd[gi*4 +: 4]);
      end
   endgenerate

   assign w_shift = {w_bcd_adj[14:0], r_bin, 1'b0};

`ifdef SCORE_LZ_BLANK_EN
   assign w_blank_m = (r_bcd[15:12] == 4'd0);
   assign w_blank_c = w_blank_m && (r_bcd[11:8] == 4'd0);
   assign w_blank_d = w_blank_c && (r_bcd[7:4] == 4'd0);
`else
   assign w_blank_m = 1'b0;
   assign w_blank_c = 1'b0;
   assign w_blank_d = 1'b0;
`endif

   assign w_dsc_m = w_blank_m ? SEG_BLANK : w_seg[3];
   assign w_dsc_c = w_blank_c ? SEG_BLANK : w_seg[2];
   assign w_dsc_d = w_blank_d ? SEG_BLANK : w_seg[1];

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (score_vld) w_state_next = CLAMP;
         CLAMP:   w_state_next = SHIFT;
         SHIFT:   if (r_cnt == 4'd13) w_state_next = UPDATE;
         UPDATE:  w_state_next = (r_pend || score_vld) ? CLAMP : IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk50 or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_work       <= '0;
         r_pend_score <= '0;
         r_pend       <= 1'b0;
         r_bin        <= '0;
         r_bcd        <= '0;
         r_cnt        <= '0;
         r_clamp_hi   <= 1'b0;
         r_clamp_lo   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_sat_hi     <= 1'b0;
         r_sat_lo     <= 1'b0;
         r_dsc_m      <= SEG_RST_LEAD;
         r_dsc_c      <= SEG_RST_LEAD;
         r_dsc_d      <= SEG_RST_LEAD;
         r_dsc_u      <= SEG_ZERO;
      end else begin
         r_state <= w_state_next;
         r_busy  <= (w_state_next != IDLE);
         r_done  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (score_vld) r_work <= score;
            end
            CLAMP: begin
               r_bin      <= w_clamped;
               r_bcd      <= '0;
               r_cnt      <= '0;
               r_clamp_hi <= w_is_hi;
               r_clamp_lo <= w_is_neg;
               if (score_vld) begin
                  r_pend_score <= score;
                  r_pend       <= 1'b1;
               end
            end
            SHIFT: begin
               r_bcd <= w_shift[29:14];
               r_bin <= w_shift[13:0];
               r_cnt <= r_cnt + 4'd1;
               if (score_vld) begin
                  r_pend_score <= score;
                  r_pend       <= 1'b1;
               end
            end
            UPDATE: begin
               r_dsc_m  <= w_dsc_m;
               r_dsc_c  <= w_dsc_c;
               r_dsc_d  <= w_dsc_d;
               r_dsc_u  <= w_seg[0];
               r_sat_hi <= r_clamp_hi;
               r_sat_lo <= r_clamp_lo;
               r_done   <= 1'b1;
               // A held request is consumed first; a fresh one arriving now becomes the new held one.
               if (r_pend) begin
                  r_work <= r_pend_score;
                  r_pend <= score_vld;
                  if (score_vld) r_pend_score <= score;
               end else if (score_vld) begin
                  r_work <= score;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign sat_hi = r_sat_hi;
   assign sat_lo = r_sat_lo;
   assign DscM   = r_dsc_m;
   assign DscC   = r_dsc_c;
   assign DscD   = r_dsc_d;
   assign DscU   = r_dsc_u;

endmodule

// File: tb/tb_score_bcd_disp.sv
// Directed bench for score_bcd_disp: a scoreboard queue of expected displays, checked on every done pulse
// for a common-anode and a common-cathode instance driven in parallel.
module tb_score_bcd_disp;

   logic               clk50 = 1'b0;
   logic               reset = 1'b0;
   logic signed [15:0] score = '0;
   logic               score_vld = 1'b0;

   logic       busy_a, done_a, sat_hi_a, sat_lo_a;
   logic [6:0] m_a, c_a, d_a, u_a;
   logic       busy_k, done_k, sat_hi_k, sat_lo_k;
   logic [6:0] m_k, c_k, d_k, u_k;

   score_bcd_disp #(.SCORE_W(16), .MAX_SCORE(9999), .TIPO_DISPLAY(0)) dut_a (
      .clk50(clk50), .reset(reset), .score(score), .score_vld(score_vld),
      .busy(busy_a), .done(done_a), .sat_hi(sat_hi_a), .sat_lo(sat_lo_a),
      .DscM(m_a), .DscC(c_a), .DscD(d_a), .DscU(u_a)
   );

   score_bcd_disp #(.SCORE_W(16), .MAX_SCORE(9999), .TIPO_DISPLAY(1)) dut_k (
      .clk50(clk50), .reset(reset), .score(score), .score_vld(score_vld),
      .busy(busy_k), .done(done_k), .sat_hi(sat_hi_k), .sat_lo(sat_lo_k),
      .DscM(m_k), .DscC(c_k), .DscD(d_k), .DscU(u_k)
   );

   always #10 clk50 = ~clk50;

   int cyc = 0;
   always @(posedge clk50) cyc <= cyc + 1;

   typedef struct {
      int val;
      bit chained;
      int req;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;
   int   last_done = 0;

   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   function automatic int clamp_val(input int s);
      if (s < 0) return 0;
      if (s > 9999) return 9999;
      return s;
   endfunction

   // Common-anode expectation {M,C,D,U}.
   function automatic logic [27:0] exp_disp(input int s);
      int v;
      int dm, dc, dd, du;
      logic [6:0] sm, sc, sd;
      v  = clamp_val(s);
      dm = v / 1000;
      dc = (v / 100) % 10;
      dd = (v / 10) % 10;
      du = v % 10;
      sm = seg_tab[dm];
      sc = seg_tab[dc];
      sd = seg_tab[dd];
`ifdef SCORE_LZ_BLANK_EN
      if (dm == 0) sm = 7'h7F;
      if (dm == 0 && dc == 0) sc = 7'h7F;
      if (dm == 0 && dc == 0 && dd == 0) sd = 7'h7F;
`endif
      return {sm, sc, sd, seg_tab[du]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic chk_disp(input string tag, input int s, input logic hi, input logic lo);
      logic [27:0] ea;
      logic [27:0] ek;
      ea = exp_disp(s);
      ek = ~ea;
      chk({tag, "_M_ca"}, m_a, ea[27:21]);
      chk({tag, "_C_ca"}, c_a, ea[20:14]);
      chk({tag, "_D_ca"}, d_a, ea[13:7]);
      chk({tag, "_U_ca"}, u_a, ea[6:0]);
      chk({tag, "_M_cc"}, m_k, ek[27:21]);
      chk({tag, "_C_cc"}, c_k, ek[20:14]);
      chk({tag, "_D_cc"}, d_k, ek[13:7]);
      chk({tag, "_U_cc"}, u_k, ek[6:0]);
      chk({tag, "_sat_hi"}, {sat_hi_k, sat_hi_a}, {hi, hi});
      chk({tag, "_sat_lo"}, {sat_lo_k, sat_lo_a}, {lo, lo});
   endtask

   always @(negedge clk50) begin
      if (reset && (done_a || done_k)) begin
         exp_t e;
         int   exp_cyc;
         done_cnt++;
         if (q.size() == 0) begin
            chk("spurious_done_queue", q.size(), 1);
         end else begin
            e = q.pop_front();
            exp_cyc = e.chained ? last_done + 16 : e.req + 16;
            $display("done score=%0d cycle=%0d", e.val, cyc);
            chk("done_both", {done_k, done_a}, 2'b11);
            chk("done_cycle", cyc, exp_cyc);
            chk_disp("disp", e.val, e.val > 9999, e.val < 0);
            last_done = cyc;
         end
      end
   end

   // mode 0: fresh request, 1: becomes the held request, 2: overwrites the held request
   task automatic send(input int s, input int mode);
      exp_t e;
      e.val = s;
      e.chained = (mode != 0);
      e.req = cyc + 1;
      if (mode == 2) q[q.size()-1] = e;
      else q.push_back(e);
      score = 16'(s);
      score_vld = 1'b1;
      @(negedge clk50);
      score_vld = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q.size() != 0 || busy_a || busy_k) && n < 200) begin
         @(negedge clk50);
         n++;
      end
      chk("idle_timeout", n < 200, 1'b1);
      @(negedge clk50);
   endtask

   task automatic chk_reset_state(input string tag);
      chk_disp(tag, 0, 1'b0, 1'b0);
      chk({tag, "_busy"}, {busy_k, busy_a}, 2'b00);
      chk({tag, "_done"}, {done_k, done_a}, 2'b00);
   endtask

   initial begin
      int bcnt;
      int d0;
      int vals[8] = '{-5, 12000, 9999, 10000, 0, -32768, 32767, 1000};

      repeat (3) @(negedge clk50);
      chk_reset_state("rst_held");
      reset = 1'b1;
      @(negedge clk50);
      chk_reset_state("rst_release");

      // Basic conversion, latency and busy width.
      send(1234, 0);
      bcnt = 0;
      for (int i = 0; i < 17; i++) begin
         if (busy_a && busy_k) bcnt++;
         @(negedge clk50);
      end
      chk("busy_cycles", bcnt, 16);
      wait_idle();

      // Held request with overwrite: 70 replaced by 95, chained with no idle gap.
      d0 = done_cnt;
      send(50, 0);
      repeat (3) @(negedge clk50);
      send(70, 1);
      repeat (3) @(negedge clk50);
      send(95, 2);
      wait_idle();
      chk("two_dones", done_cnt - d0, 2);

      // Clamp boundaries, ending on a saturated value.
      foreach (vals[i]) begin
         send(vals[i], 0);
         wait_idle();
      end
      send(12000, 0);
      wait_idle();
      chk("sat_hi_before_reset", sat_hi_a, 1'b1);

      // Reset mid-conversion with a held request: both discarded, no done.
      send(4321, 0);
      repeat (2) @(negedge clk50);
      send(55, 1);
      repeat (5) @(negedge clk50);
      #5 reset = 1'b0;
      q.delete();
      #1 chk_reset_state("rst_mid");
      @(negedge clk50);
      reset = 1'b1;
      d0 = done_cnt;
      repeat (20) @(negedge clk50);
      chk("no_done_after_abort", done_cnt - d0, 0);
      chk_reset_state("rst_after");

      send(4321, 0);
      wait_idle();
      send(7, 0);
      wait_idle();
      send(-1, 0);
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
